// File: rtl/router_outport.sv
// -----------------------------------------------------------------------------
// router_outport
//
// Output-port stage of the router. Sits directly downstream of the per-link
// input buffers, arbitrates between NIN byte streams at packet granularity and
// forwards the granted stream through a single registered output stage.
//
// Packet format: one header byte followed by hdr[LENW-1:0] payload bytes. Once
// an input is granted it keeps the grant until its whole packet has passed,
// however long that takes (no timeout, no preemption).
//
// Handshake (all streams): a byte moves on a rising clk edge when valid and
// ready are both high in that cycle. A source holds valid and data stable
// until accepted; ready may be asserted or withdrawn at any time.
//
// Optional build macro:
//   ROUTER_OUTPORT_PRIO_EN - input 0 gets strict priority at arbitration time;
//                            the round-robin pointer then cycles over inputs
//                            1..NIN-1 only and is not moved by grants to 0.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   in_valid     per-input byte valid (from input buffer rvalid)
//   in_data      per-input bytes, input i at [i*DW +: DW]
//   in_rdy       per-input accept (to input buffer rrdy), combinational
//   out_valid    output byte valid, registered
//   out_data     output byte, registered
//   out_rdy      downstream accept
//   out_sop      registered, high while out_data holds a header byte
//   dbg_state    FSM state (0 = IDLE, 1 = XFER)
//   dbg_grant    currently granted input
//   dbg_rr_ptr   round-robin search start for the next arbitration
// -----------------------------------------------------------------------------
module router_outport #(
  parameter int NIN  = 4,
  parameter int DW   = 8,
  parameter int LENW = 3,
  localparam int GW  = $clog2(NIN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NIN-1:0]    in_valid,
  input  logic [NIN*DW-1:0] in_data,
  output logic [NIN-1:0]    in_rdy,
  output logic              out_valid,
  output logic [DW-1:0]     out_data,
  input  logic              out_rdy,
  output logic              out_sop,
  output logic              dbg_state,
  output logic [GW-1:0]     dbg_grant,
  output logic [GW-1:0]     dbg_rr_ptr
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

`ifdef ROUTER_OUTPORT_PRIO_EN
  // Input 0 sits outside the round-robin ring, so the pointer starts at 1.
  localparam logic [GW-1:0] RR_RST = GW'(1);
`else
  localparam logic [GW-1:0] RR_RST = '0;
`endif

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q;
  logic [GW-1:0]   rr_ptr_q;
  logic [LENW-1:0] remaining_q;
  logic            first_q;

  logic [DW-1:0]   sel_data;
  logic [LENW-1:0] hdr_len;
  logic            out_free;
  logic            xfer;
  logic            pkt_end;
  logic [GW-1:0]   arb_win;
  logic [GW-1:0]   arb_idx;
  logic            arb_found;
  logic [GW-1:0]   rr_next;
`ifdef ROUTER_OUTPORT_PRIO_EN
  int              arb_j;
`endif

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------

  // Byte currently offered by the granted input.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NIN; i++) begin
      if (grant_q == GW'(i)) sel_data = in_data[i*DW +: DW];
    end
  end

  assign hdr_len  = sel_data[LENW-1:0];
  // The output register can take a new byte if it is empty or draining now.
  assign out_free = !out_valid || out_rdy;
  assign xfer     = in_valid[grant_q] && in_rdy[grant_q];
  // End is decided before the decrement, so remaining never wraps below 0.
  assign pkt_end  = xfer && (first_q ? (hdr_len == '0)
                                     : (remaining_q == LENW'(1)));

  // ---------------------------------------------------------------------------
  // Arbiter: first valid input at or after rr_ptr, with wrap.
  // ---------------------------------------------------------------------------
`ifdef ROUTER_OUTPORT_PRIO_EN
  always_comb begin
    arb_win   = rr_ptr_q;
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_j     = 0;
    if (in_valid[0]) begin
      arb_win   = '0;
      arb_found = 1'b1;
    end else begin
      // Ring over 1..NIN-1 only; NIN-1 wraps back to 1.
      for (int k = 0; k < NIN - 1; k++) begin
        arb_j = int'(rr_ptr_q) + k;
        if (arb_j > NIN - 1) arb_j = arb_j - (NIN - 1);
        arb_idx = GW'(arb_j);
        if (!arb_found && in_valid[arb_idx]) begin
          arb_win   = arb_idx;
          arb_found = 1'b1;
        end
      end
    end
  end

  // Grants to input 0 leave the ring position untouched.
  always_comb begin
    if (grant_q == '0) begin
      rr_next = rr_ptr_q;
    end else if (grant_q == GW'(NIN - 1)) begin
      rr_next = GW'(1);
    end else begin
      rr_next = grant_q + GW'(1);
    end
  end
`else
  always_comb begin
    arb_win   = rr_ptr_q;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 0; k < NIN; k++) begin
      // NIN is a power of two, so the GW-bit sum wraps modulo NIN.
      arb_idx = rr_ptr_q + GW'(k);
      if (!arb_found && in_valid[arb_idx]) begin
        arb_win   = arb_idx;
        arb_found = 1'b1;
      end
    end
  end

  assign rr_next = grant_q + GW'(1);
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|in_valid) state_d = XFER;
      XFER:    if (pkt_end)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. Only the granted input can be accepted, and only while
  // the output register has room; IDLE is a pure arbitration bubble.
  always_comb begin
    in_rdy = '0;
    if (state_q == XFER && out_free) in_rdy[grant_q] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Grant / packet tracking and output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q     <= '0;
      rr_ptr_q    <= RR_RST;
      remaining_q <= '0;
      first_q     <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sop     <= 1'b0;
    end else begin
      if (state_q == IDLE && |in_valid) begin
        grant_q <= arb_win;
        first_q <= 1'b1;
      end

      if (xfer) begin
        if (first_q) begin
          remaining_q <= hdr_len;
          first_q     <= 1'b0;
        end else begin
          remaining_q <= remaining_q - LENW'(1);
        end
      end

      if (pkt_end) rr_ptr_q <= rr_next;

      // A load in the same cycle as a drain replaces the byte with no bubble.
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sop   <= first_q;
      end else if (out_valid && out_rdy) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign dbg_state  = state_q;
  assign dbg_grant  = grant_q;
  assign dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_router_outport.sv
module tb_router_outport;

  localparam int NIN  = 4;
  localparam int DW   = 8;
  localparam int LENW = 3;
  localparam int GW   = $clog2(NIN);
`ifdef ROUTER_OUTPORT_PRIO_EN
  localparam int PTR_RST = 1;
`else
  localparam int PTR_RST = 0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [NIN-1:0]    in_valid;
  logic [NIN*DW-1:0] in_data;
  logic [NIN-1:0]    in_rdy;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic              out_rdy;
  logic              out_sop;
  logic              dbg_state;
  logic [GW-1:0]     dbg_grant;
  logic [GW-1:0]     dbg_rr_ptr;

  router_outport #(.NIN(NIN), .DW(DW), .LENW(LENW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_rdy     (in_rdy),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_rdy    (out_rdy),
    .out_sop    (out_sop),
    .dbg_state  (dbg_state),
    .dbg_grant  (dbg_grant),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // ---------------------------------------------------------------------------
  // Bench state
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [DW-1:0] src_q [NIN][$];   // bytes still to be offered by each input
  logic [DW:0]   exp_q [$];        // expected {sop, byte} on the output
  int            sop_cyc [$];      // cycle stamps of accepted header bytes
  int            rem_b [NIN];      // payload bytes left in an input's open packet
  int            drop_cnt [NIN];   // forced in_valid low cycles
  int            rdy_pct  = 100;
  int            stall_cnt = 0;
  bit            drop_en  = 1'b0;
  int            m_ptr    = PTR_RST;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: packet-level arbitration over everything queued.
  // All packets of a phase are queued before the phase starts, so every
  // non-empty input is requesting at each arbitration.
  // ---------------------------------------------------------------------------
  task automatic model_run();
    logic [DW-1:0] mq [NIN][$];
    logic [DW-1:0] hdr;
    int w, j, len;
    bit any;
    for (int i = 0; i < NIN; i++) mq[i] = src_q[i];
    forever begin
      any = 1'b0;
      for (int i = 0; i < NIN; i++) if (mq[i].size() > 0) any = 1'b1;
      if (!any) break;
      w = -1;
`ifdef ROUTER_OUTPORT_PRIO_EN
      if (mq[0].size() > 0) w = 0;
      for (int k = 0; k < NIN - 1; k++) begin
        j = 1 + ((m_ptr - 1 + k) % (NIN - 1));
        if (w < 0 && mq[j].size() > 0) w = j;
      end
      if (w != 0) m_ptr = (w == NIN - 1) ? 1 : w + 1;
`else
      for (int k = 0; k < NIN; k++) begin
        j = (m_ptr + k) % NIN;
        if (w < 0 && mq[j].size() > 0) w = j;
      end
      m_ptr = (w + 1) % NIN;
`endif
      hdr = mq[w].pop_front();
      exp_q.push_back({1'b1, hdr});
      len = int'(hdr[LENW-1:0]);
      for (int k = 0; k < len; k++) exp_q.push_back({1'b0, mq[w].pop_front()});
    end
  endtask

  task automatic push_byte(input int i, input logic [DW-1:0] b);
    src_q[i].push_back(b);
  endtask

  function automatic bit src_busy();
    bit b = 1'b0;
    for (int i = 0; i < NIN; i++) if (src_q[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || src_busy()) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_exp_left", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic flush_all();
    exp_q.delete();
    for (int i = 0; i < NIN; i++) begin
      src_q[i].delete();
      rem_b[i]    = 0;
      drop_cnt[i] = 0;
    end
    stall_cnt = 0;
    m_ptr     = PTR_RST;
  endtask

  // ---------------------------------------------------------------------------
  // Driver: input-buffer emulation and downstream ready
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic v;
    logic [DW-1:0] b;
    for (int i = 0; i < NIN; i++) begin
      if (drop_cnt[i] > 0) begin
        v = 1'b0;
        drop_cnt[i]--;
      end else if (drop_en && rem_b[i] > 0 && $urandom_range(0, 5) == 0) begin
        v = 1'b0;
        drop_cnt[i] = 1;
      end else begin
        v = (src_q[i].size() > 0);
      end
      in_valid[i] = v;
      in_data[i*DW +: DW] = v ? src_q[i][0] : DW'($urandom);
    end
    if (stall_cnt > 0) begin
      out_rdy = 1'b0;
      stall_cnt--;
    end else begin
      out_rdy = ($urandom_range(1, 100) <= rdy_pct);
    end
    #1;
    if (rst_n) begin
      for (int i = 0; i < NIN; i++) begin
        if (in_valid[i] && in_rdy[i]) begin
          b = src_q[i].pop_front();
          if (rem_b[i] == 0) rem_b[i] = int'(b[LENW-1:0]);
          else rem_b[i]--;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic          prev_hold;
    logic [DW:0]   prev_byte;
    logic [DW:0]   e;
    #2;
    cyc++;
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("stall_hold_valid", out_valid, 1'b1);
        check("stall_hold_data", {out_sop, out_data}, prev_byte);
      end
      check("in_rdy_onehot0", $onehot0(in_rdy), 1'b1);
      if (out_valid && !out_rdy) check("stall_in_rdy", in_rdy, '0);
      if (out_valid && out_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", {out_sop, out_data}, {1'b1, {DW{1'b1}}} + 1'b1);
        end else begin
          e = exp_q.pop_front();
          check("out_byte", {out_sop, out_data}, e);
          if (out_sop) sop_cyc.push_back(cyc);
        end
      end
      prev_hold = out_valid && !out_rdy;
      prev_byte = {out_sop, out_data};
    end
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int lat, n, np, len;
    logic [DW-1:0] hdr;
    rst_n    = 1'b0;
    in_valid = '0;
    in_data  = '0;
    out_rdy  = 1'b0;
    flush_all();

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_sop", out_sop, 1'b0);
    check("rst_in_rdy", in_rdy, '0);
    check("rst_state", dbg_state, 1'b0);
    check("rst_grant", dbg_grant, '0);
    check("rst_rr_ptr", dbg_rr_ptr, PTR_RST);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single packet on input 2: latency, content, then pointer position.
    rdy_pct = 100;
    push_byte(2, 8'h02); push_byte(2, 8'hA1); push_byte(2, 8'hA2);
    model_run();
    @(negedge clk); #3;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("first_latency", lat, 2);
    wait_drain(200);
    check("idle_after_pkt", dbg_state, 1'b0);
    check("rr_ptr_after_pkt", dbg_rr_ptr, m_ptr);
    check("rr_ptr_is_3", dbg_rr_ptr, 3);

    // Asynchronous reset in the middle of a payload.
    push_byte(1, 8'h05);
    for (int k = 0; k < 5; k++) push_byte(1, 8'hC0 + DW'(k));
    model_run();
    n = 0;
    while (!(out_valid && !out_sop) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_mid_payload", n < 50, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_in_rdy", in_rdy, '0);
    check("async_rst_state", dbg_state, 1'b0);
    flush_all();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_state", dbg_state, 1'b0);
    check("post_rst_rr_ptr", dbg_rr_ptr, PTR_RST);
    push_byte(3, 8'h01); push_byte(3, 8'h3C);
    model_run();
    wait_drain(200);

    // Zero-length packets from every input: order and one-cycle gaps.
    push_byte(0, 8'h10); push_byte(1, 8'h20); push_byte(2, 8'h30);
    push_byte(3, 8'h40); push_byte(0, 8'h50);
    sop_cyc.delete();
    model_run();
    wait_drain(200);
    check("zero_len_pkts", sop_cyc.size(), 5);
    for (int k = 1; k < sop_cyc.size(); k++)
      check("pkt_gap", sop_cyc[k] - sop_cyc[k-1], 2);

    // Backpressure for 3 cycles during a 4-byte payload.
    push_byte(1, 8'h04);
    for (int k = 0; k < 4; k++) push_byte(1, 8'hD0 + DW'(k));
    model_run();
    n = 0;
    while (!(out_valid && !out_sop) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_payload_bp", n < 50, 1'b1);
    stall_cnt = 3;
    wait_drain(200);

    // Granted input 3 drops valid for 2 cycles while input 1 waits.
    push_byte(3, 8'h04);
    for (int k = 0; k < 4; k++) push_byte(3, 8'hE0 + DW'(k));
    push_byte(1, 8'h01); push_byte(1, 8'h77);
    model_run();
    n = 0;
    while (rem_b[3] == 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_hdr_drop", n < 50, 1'b1);
    drop_cnt[3] = 2;
    wait_drain(200);

    // Maximum length header.
    push_byte(0, 8'h07);
    for (int k = 0; k < 7; k++) push_byte(0, 8'hB0 + DW'(k));
    sop_cyc.delete();
    model_run();
    wait_drain(200);
    check("len7_one_sop", sop_cyc.size(), 1);

    // Randomised phases with backpressure and mid-packet valid drops.
    drop_en = 1'b1;
    for (int r = 0; r < 20; r++) begin
      rdy_pct = $urandom_range(30, 100);
      for (int i = 0; i < NIN; i++) begin
        np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) begin
          len = $urandom_range(0, (1 << LENW) - 1);
          hdr = DW'($urandom);
          hdr[LENW-1:0] = LENW'(len);
          push_byte(i, hdr);
          for (int k = 0; k < len; k++) push_byte(i, DW'($urandom));
        end
      end
      model_run();
      wait_drain(3000);
      check("rand_rr_ptr", dbg_rr_ptr, m_ptr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
